dbg_read_port: RTL

DBG_READ_PORT -- requirements
Module: dbg_read_port

---
 rtl/dbg_pkg.sv | 20 ++
 rtl/dbg_wait_timer.sv | 30 +++
 rtl/dbg_read_port.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// Shared definitions for the debug read port: FSM state encoding, data width
// and the timeout constants used when DBG_READ_TIMEOUT_EN is defined.
package dbg_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_REG = 3'd1,
    ST_RD_MEM = 3'd2,
    ST_CAP    = 3'd3,
    ST_RESP   = 3'd4
  } dbg_state_e;

  // Substitute read data returned when the CPU never grants the memory port.
  localparam logic [DATA_W-1:0] DBG_TIMEOUT_DATA  = 32'hDEAD_BEEF;
  // Number of ungranted RD_MEM cycles after which the read is abandoned.
  localparam logic [7:0]        DBG_TIMEOUT_LIMIT = 8'd255;

endpackage

// File: rtl/dbg_wait_timer.sv
// Wait-cycle counter for the memory read path. Counts cycles with count=1,
// restarts from zero on clear, and flags expiry combinationally in the cycle
// that would bring the count to DBG_TIMEOUT_LIMIT, so the owner can react on
// the same clock edge. Only instantiated when DBG_READ_TIMEOUT_EN is defined.
module dbg_wait_timer
  import dbg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  logic [7:0] cnt;

  // Wait-cycle counter: cleared outside the wait state, advanced per stalled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clear) begin
      cnt <= 8'd0;
    end else if (count) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = count && (cnt == (DBG_TIMEOUT_LIMIT - 8'd1));

endmodule

// File: rtl/dbg_read_port.sv
// Debug read port: accepts one read request at a time from a display/debug
// initiator, reads either the CPU register file or a data-memory word, and
// returns the data through a valid/ready response channel.
// Optional feature: define DBG_READ_TIMEOUT_EN to abandon memory reads that
// are never granted (returns DBG_TIMEOUT_DATA and raises the sticky err flag).
// Without it, memory reads wait for the grant indefinitely and err is 0.
module dbg_read_port
  import dbg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  // request side
  input  logic              req_valid,
  input  logic              req_is_mem,
  input  logic [5:0]        req_addr,
  output logic              req_ready,
  // response side
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  input  logic              resp_ready,
  output logic              err,
  output logic [15:0]       resp_cnt,
  // CPU register file
  output logic              rf_re,
  output logic [4:0]        rf_ra,
  input  logic [DATA_W-1:0] rf_rd,
  // CPU data memory
  output logic              mem_re,
  output logic [5:0]        mem_ra,
  input  logic              mem_gnt,
  input  logic [DATA_W-1:0] mem_rd
);

  dbg_state_e  state;
  logic        is_mem_q;
  logic [5:0]  addr_q;
  logic        rdy_q;
  logic [15:0] resp_cnt_q;
  logic        accept;
  logic        resp_hs;
  logic        tmo;

  assign accept  = req_valid & rdy_q;
  assign resp_hs = resp_valid & resp_ready;

  // Addresses come straight from the latched request; only the read enables
  // qualify them, so they need no separate per-state registers.
  assign rf_ra     = addr_q[4:0];
  assign mem_ra    = addr_q;
  assign req_ready = rdy_q;
  assign resp_cnt  = resp_cnt_q;

`ifdef DBG_READ_TIMEOUT_EN
  logic err_q;

  dbg_wait_timer u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != ST_RD_MEM),
    .count   ((state == ST_RD_MEM) && !mem_gnt),
    .expired (tmo)
  );

  // Sticky timeout flag: set when a memory read is abandoned, cleared by the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if ((state == ST_RD_MEM) && tmo) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  // Request/response FSM with registered outputs; req_ready is low during
  // reset and rises on the first clock edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      is_mem_q   <= 1'b0;
      addr_q     <= 6'd0;
      rdy_q      <= 1'b0;
      rf_re      <= 1'b0;
      mem_re     <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          rdy_q <= 1'b1;
          if (accept) begin
            rdy_q    <= 1'b0;
            is_mem_q <= req_is_mem;
            addr_q   <= req_addr;
            if (req_is_mem) begin
              mem_re <= 1'b1;
              state  <= ST_RD_MEM;
            end else begin
              rf_re <= 1'b1;
              state <= ST_RD_REG;
            end
          end
        end
        ST_RD_REG: begin
          rf_re <= 1'b0;
          state <= ST_CAP;
        end
        ST_RD_MEM: begin
          if (mem_gnt) begin
            mem_re <= 1'b0;
            state  <= ST_CAP;
          end else if (tmo) begin
            mem_re     <= 1'b0;
            resp_data  <= DBG_TIMEOUT_DATA;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_CAP: begin
          resp_data  <= is_mem_q ? mem_rd : rf_rd;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rdy_q      <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          rf_re      <= 1'b0;
          mem_re     <= 1'b0;
          resp_valid <= 1'b0;
          rdy_q      <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Completed-response counter; free-running 16-bit wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_cnt_q <= 16'd0;
    end else begin
      resp_cnt_q <= resp_cnt_q + {15'd0, resp_hs};
    end
  end

endmodule
